// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: buffers a payload burst, then sends SYNC, LEN, DATA, CSUM.
// Define UART_PKT_PARITY_EN to add an even-parity bit to every frame.
module uart_packet_tx #(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter int         BAUD_RATE = 12_000_000,
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       last_in,
  output logic       ready_out,
  output logic       uart_tx_out,
  output logic       busy_out
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int BW    = $clog2(CPB + 1);
  localparam int CW    = $clog2(MAX_LEN + 1);
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 2 ** IW;
`ifdef UART_PKT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(NB - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_LEN);

  typedef enum logic [2:0] {FILL, SYNC, LEN, DATA, CSUM} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_q, rd_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      byte_q, byte_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [3:0]      bit_nx;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [NB-1:0]   frame;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
`ifdef UART_PKT_PARITY_EN
    frame = {1'b1, ^byte_q, byte_q, 1'b0};
`else
    frame = {1'b1, byte_q, 1'b0};
`endif
    bit_nx = bit_q + 4'd1;
    unique case (state_q)
      FILL: begin
        if (valid_in && ready_q) begin
          mem_d[IW'(count_q)] = data_in;
          count_d = count_q + CW'(1);
          csum_d  = csum_q + data_in;
          if (last_in || count_d == CNT_MAX) begin
            state_d = SYNC;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            byte_d  = SYNC_BYTE;
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
          end
        end
      end
      default: begin
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + BW'(1);
        end else begin
          baud_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d = bit_nx;
            tx_d  = frame[bit_nx];
          end else begin
            // stop bit done: next start bit follows with no gap
            bit_d = '0;
            tx_d  = 1'b0;
            case (state_q)
              SYNC: begin
                state_d = LEN;
                byte_d  = 8'(count_q);
              end
              LEN: begin
                state_d = DATA;
                byte_d  = mem_q[0];
                rd_d    = CW'(1);
              end
              DATA: begin
                if (rd_q == count_q) begin
                  state_d = CSUM;
                  byte_d  = csum_q;
                end else begin
                  byte_d = mem_q[IW'(rd_q)];
                  rd_d   = rd_q + CW'(1);
                end
              end
              default: begin
                state_d = FILL;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                count_d = '0;
                csum_d  = '0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= FILL;
      count_q <= '0;
      rd_q    <= '0;
      csum_q  <= '0;
      byte_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      csum_q  <= csum_d;
      byte_q  <= byte_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  assign ready_out   = ready_q;
  assign uart_tx_out = tx_q;
  assign busy_out    = busy_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: decodes the serial line and checks packets.
// Honours UART_PKT_PARITY_EN for frame length and parity checks.
module tb_uart_packet_tx;

  localparam int CPB = 8;
`ifdef UART_PKT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       last_in = 1'b0;
  logic       ready_out;
  logic       uart_tx_out;
  logic       busy_out;

  uart_packet_tx dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .last_in     (last_in),
    .ready_out   (ready_out),
    .uart_tx_out (uart_tx_out),
    .busy_out    (busy_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int rx_cnt = -1;
  logic [10:0] sh = '0;
  logic [7:0]  rxq [$];
  int          startq [$];
  logic        parq [$];
  logic [7:0]  expq [$];
  logic [7:0]  plq [$];
  int busy_run = 0;
  int rdy_run = 0;
  int last_busy = 0;
  int last_rdy = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // line monitor: one sample per cycle, mid-bit decode
  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (busy_out) busy_run++;
    else if (busy_run > 0) begin
      last_busy = busy_run;
      busy_run = 0;
    end
    if (!ready_out) rdy_run++;
    else if (rdy_run > 0) begin
      last_rdy = rdy_run;
      rdy_run = 0;
    end
    if (!rst_in) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (!uart_tx_out) begin
        rx_cnt = 0;
        startq.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        int k;
        k = rx_cnt / CPB;
        sh[k] = uart_tx_out;
        if (k == NB - 1) begin
          rxq.push_back(sh[8:1]);
          check("stop_bit", 32'(sh[NB-1]), 32'd1);
`ifdef UART_PKT_PARITY_EN
          parq.push_back(sh[9]);
          check("parity_bit", 32'(sh[9]), 32'(^sh[8:1]));
`endif
          rx_cnt = -1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk_in);
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    while (!ready_out && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk_in);
    hs_cyc = cyc;
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_in);
    while ((busy_out || !ready_out) && n < 4000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 4000) check("idle_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic build_exp();
    logic [7:0] s = 8'h00;
    expq.push_back(8'hA5);
    expq.push_back(8'(plq.size()));
    foreach (plq[i]) begin
      expq.push_back(plq[i]);
      s = s + plq[i];
    end
    expq.push_back(s);
    plq.delete();
  endtask

  task automatic cmp_rx(input string tag);
    logic [31:0] g;
    check({tag, "_nbytes"}, 32'(rxq.size()), 32'(expq.size()));
    foreach (expq[i]) begin
      g = 'x;
      if (i < rxq.size()) g = 32'(rxq[i]);
      check(tag, g, 32'(expq[i]));
    end
    rxq.delete();
    expq.delete();
    startq.delete();
    parq.delete();
  endtask

  initial begin
    int h;
    repeat (3) @(negedge clk_in);
    check("rst_tx", 32'(uart_tx_out), 32'd1);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_busy", 32'(busy_out), 32'd0);
    rst_in = 1'b1;

    // last_in without valid_in must not close a packet
    @(negedge clk_in);
    last_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("lone_last_busy", 32'(busy_out), 32'd0);
    check("lone_last_tx", 32'(uart_tx_out), 32'd1);
    last_in = 1'b0;

    // three-byte packet
    plq = '{8'h01, 8'h02, 8'h03};
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    h = hs_cyc;
    wait_idle();
    build_exp();
    check("t1_first_start", 32'(startq[0]), 32'(h + 1));
    for (int i = 0; i < 5; i++)
      check("t1_byte_gap", 32'(startq[i+1] - startq[i]), 32'(FRAME));
    check("t1_busy_len", 32'(last_busy), 32'(6 * FRAME));
    check("t1_ready_low", 32'(last_rdy), 32'(6 * FRAME));
    cmp_rx("t1");

    // overflow: 16 bytes close the packet, the 17th waits
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h10 + i), 1'b0);
      if (i == 15) begin
        @(negedge clk_in);
        check("t2_ready_drop", 32'(ready_out), 32'd0);
      end
      if (i == 16) begin
        check("t2_hold", 32'(hs_cyc >= startq[18] + FRAME), 32'd1);
        build_exp();
        cmp_rx("t2a");
      end
      if (i < 16 || i > 16) plq.push_back(8'(8'h10 + i));
      if (i == 16) plq.push_back(8'h20);
    end
    send(8'h24, 1'b1);
    plq.push_back(8'h24);
    wait_idle();
    build_exp();
    cmp_rx("t2b");

    // single byte
    plq = '{8'hFF};
    send(8'hFF, 1'b1);
    wait_idle();
    build_exp();
    check("t3_busy_len", 32'(last_busy), 32'(4 * FRAME));
    cmp_rx("t3");

    // reset in the middle of LEN
    send(8'h01, 1'b1);
    repeat (1 + FRAME + FRAME / 2) @(negedge clk_in);
    check("t4_pre_tx", 32'(uart_tx_out), 32'd0);
    #2;
    rst_in = 1'b0;
    #1;
    check("t4_rst_tx", 32'(uart_tx_out), 32'd1);
    check("t4_rst_ready", 32'(ready_out), 32'd1);
    check("t4_rst_busy", 32'(busy_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    rxq.delete();
    startq.delete();
    parq.delete();
    repeat (200) @(negedge clk_in);
    check("t4_no_resume", 32'(startq.size()), 32'd0);
    check("t4_idle_busy", 32'(busy_out), 32'd0);
    plq = '{8'h42};
    send(8'h42, 1'b1);
    wait_idle();
    build_exp();
    cmp_rx("t4");

    // back-to-back packets
    send(8'h7F, 1'b1);
    send(8'h80, 1'b1);
    wait_idle();
    check("t5_idle_gap", 32'(startq[4] - startq[3] - FRAME >= 1), 32'd1);
    plq = '{8'h7F};
    build_exp();
    plq = '{8'h80};
    build_exp();
    cmp_rx("t5");

    // payload 0x03
    plq = '{8'h03};
    send(8'h03, 1'b1);
    wait_idle();
    build_exp();
    check("t6_busy_len", 32'(last_busy), 32'(4 * FRAME));
`ifdef UART_PKT_PARITY_EN
    check("t6_npar", 32'(parq.size()), 32'd4);
    check("t6_par_sync", 32'(parq[0]), 32'd0);
    check("t6_par_len", 32'(parq[1]), 32'd1);
    check("t6_par_data", 32'(parq[2]), 32'd0);
    check("t6_par_csum", 32'(parq[3]), 32'd0);
`endif
    cmp_rx("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
